// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, functs, field encodings and the ID/EX bundle.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_SPEC2  = 6'h1c;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_BR = 3'b001, ALU_R = 3'b010,
        ALU_AND = 3'b100, ALU_SLT = 3'b101, ALU_SP2 = 3'b110
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'b000, BR_NE = 3'b001, BR_LEZ = 3'b010,
        BR_GTZ = 3'b011, BR_LTZ = 3'b100, BR_NONE = 3'b111
    } branch_op_e;

    typedef enum logic [1:0] {WD_RT = 2'b00, WD_RD = 2'b01, WD_R31 = 2'b10} write_dst_e;
    typedef enum logic [1:0] {M2R_ALU = 2'b00, M2R_MEM = 2'b01, M2R_PC = 2'b10} memto_reg_e;
    typedef enum logic [1:0] {HL_NONE = 2'b00, HL_HI = 2'b01, HL_LO = 2'b10} hilo_rd_e;
    typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

    // MSB is a reserved zero bit that pads the bundle to its 24-bit port width.
    typedef struct packed {
        logic       rsvd;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        memto_reg_e memtoReg;
        write_dst_e writeDst;
        logic       aluSrc1;
        logic       aluSrc2;
        logic       extOp;
        logic       luOp;
        logic [3:0] aluOp;
        logic       jump;
        logic       branch;
        branch_op_e branchOp;
        logic       hiLoWr;
        hilo_rd_e   hiLoRd;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide unit sequencer: IDLE/BUSY FSM with a latency down-counter and registered status pulses.
module md_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [1:0] op,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 32'sd1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] loadVal_s;
    logic             start_r;
    logic [1:0]       op_r;
    logic             busy_r;
    logic             done_r;

    assign loadVal_s = op[1] ? DIV_LOAD : MUL_LOAD;

    // Issue loads latency-1; done is registered one edge early so it lines up with count zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
            start_r <= 1'b0;
            op_r    <= MD_MULT;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (issue) begin
                        state_r <= MD_BUSY;
                        cnt_r   <= loadVal_s;
                        start_r <= 1'b1;
                        op_r    <= op;
                        busy_r  <= 1'b1;
                        done_r  <= (loadVal_s == '0);
                    end else begin
                        start_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                MD_BUSY: begin
                    start_r <= 1'b0;
                    if (cnt_r == '0) begin
                        state_r <= MD_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        done_r <= (cnt_r == CNT_ONE);
                    end
                end
                default: begin
                    state_r <= MD_IDLE;
                    cnt_r   <= '0;
                    start_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign md_start = start_r;
    assign md_op    = op_r;
    assign md_busy  = busy_r;
    assign md_done  = done_r;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX control register, load-use and MD hazard stall, MD sequencing.
// Build macro PIPE_CTRL_ILLEGAL_TRAP_EN adds a registered illegal_instr pulse and bubbles unknown encodings.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic [4:0]           Rs,
    input  logic [4:0]           Rt,
    input  logic                 flush,
    output logic                 stall_id,
    output logic                 ex_valid,
    output logic [EX_CTRL_W-1:0] ex_ctrl,
    output logic [4:0]           ex_rt,
    output logic                 md_start,
    output logic [1:0]           md_op,
    output logic                 md_busy,
    output logic                 md_done
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_instr
`endif
);

    ex_ctrl_t   dec_s;
    ex_ctrl_t   enterCtrl_s;
    ex_ctrl_t   exCtrl_r;
    logic       legal_s;
    logic       usesRt_s;
    logic       isMd_s;
    logic       hiLoUse_s;
    logic [1:0] mdOp_s;
    logic       loadUse_s;
    logic       mdHazard_s;
    logic       issue_s;
    logic       enterValid_s;
    logic       exValid_r;
    logic [4:0] exRt_r;

    // Decode starts from the common non-R defaults; unknown encodings are zeroed afterwards.
    always_comb begin
        dec_s          = '0;
        dec_s.extOp    = 1'b1;
        dec_s.aluSrc2  = 1'b1;
        dec_s.branchOp = BR_NONE;
        dec_s.aluOp    = {Opcode[0], ALU_ADD};
        legal_s        = 1'b1;
        usesRt_s       = 1'b0;
        isMd_s         = 1'b0;
        hiLoUse_s      = 1'b0;
        mdOp_s         = MD_MULT;
        case (Opcode)
            OP_RTYPE: begin
                dec_s.regWrite = 1'b1;
                dec_s.writeDst = WD_RD;
                dec_s.aluSrc2  = 1'b0;
                dec_s.aluOp    = {Opcode[0], ALU_R};
                usesRt_s       = 1'b1;
                case (Funct)
                    FN_SLL, FN_SRL, FN_SRA: dec_s.aluSrc1 = 1'b1;
                    FN_JR: begin
                        dec_s.regWrite = 1'b0;
                        dec_s.jump     = 1'b1;
                    end
                    FN_JALR: begin
                        dec_s.jump     = 1'b1;
                        dec_s.memtoReg = M2R_PC;
                    end
                    FN_MFHI: begin
                        dec_s.hiLoRd = HL_HI;
                        hiLoUse_s    = 1'b1;
                    end
                    FN_MFLO: begin
                        dec_s.hiLoRd = HL_LO;
                        hiLoUse_s    = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        dec_s.regWrite = 1'b0;
                        dec_s.hiLoWr   = 1'b1;
                        hiLoUse_s      = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec_s.regWrite = 1'b0;
                        isMd_s         = 1'b1;
                        mdOp_s         = md_op_e'(Funct[1:0]);
                    end
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: dec_s.aluSrc1 = 1'b0;
                    default: legal_s = 1'b0;
                endcase
            end
            OP_J: dec_s.jump = 1'b1;
            OP_JAL: begin
                dec_s.jump     = 1'b1;
                dec_s.regWrite = 1'b1;
                dec_s.memtoReg = M2R_PC;
                dec_s.writeDst = WD_R31;
            end
            OP_BEQ, OP_BNE: begin
                dec_s.branch   = 1'b1;
                dec_s.branchOp = Opcode[0] ? BR_NE : BR_EQ;
                dec_s.aluSrc2  = 1'b0;
                dec_s.aluOp    = {Opcode[0], ALU_BR};
                usesRt_s       = 1'b1;
            end
            OP_BLEZ: begin
                dec_s.branch   = 1'b1;
                dec_s.branchOp = BR_LEZ;
            end
            OP_BGTZ: begin
                dec_s.branch   = 1'b1;
                dec_s.branchOp = BR_GTZ;
            end
            OP_REGIMM: begin
                dec_s.branch   = 1'b1;
                dec_s.branchOp = BR_LTZ;
            end
            OP_ADDI, OP_ADDIU: dec_s.regWrite = 1'b1;
            OP_SLTI, OP_SLTIU: begin
                dec_s.regWrite = 1'b1;
                dec_s.aluOp    = {Opcode[0], ALU_SLT};
            end
            OP_ANDI: begin
                dec_s.regWrite = 1'b1;
                dec_s.extOp    = 1'b0;
                dec_s.aluOp    = {Opcode[0], ALU_AND};
            end
            OP_LUI: begin
                dec_s.regWrite = 1'b1;
                dec_s.luOp     = 1'b1;
            end
            OP_SPEC2: dec_s.aluOp = {Opcode[0], ALU_SP2};
            OP_LW: begin
                dec_s.regWrite = 1'b1;
                dec_s.memRead  = 1'b1;
                dec_s.memtoReg = M2R_MEM;
            end
            OP_SW: begin
                dec_s.memWrite = 1'b1;
                usesRt_s       = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

    assign loadUse_s  = exValid_r && exCtrl_r.memRead && (exRt_r != 5'd0) &&
                        ((exRt_r == Rs) || ((exRt_r == Rt) && usesRt_s));
    assign mdHazard_s = md_busy && (hiLoUse_s || isMd_s);
    assign stall_id   = id_valid && !flush && (loadUse_s || mdHazard_s);
    assign issue_s    = id_valid && !flush && !stall_id && isMd_s;

    assign enterCtrl_s = (id_valid && legal_s) ? dec_s : '0;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    assign enterValid_s = id_valid && legal_s;
`else
    assign enterValid_s = id_valid;
`endif

    // ID/EX boundary: flush or stall inserts a bubble, otherwise the decoded instruction advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exValid_r <= 1'b0;
            exCtrl_r  <= '0;
            exRt_r    <= 5'd0;
        end else if (flush || stall_id) begin
            exValid_r <= 1'b0;
            exCtrl_r  <= '0;
            exRt_r    <= 5'd0;
        end else begin
            exValid_r <= enterValid_s;
            exCtrl_r  <= enterCtrl_s;
            exRt_r    <= enterValid_s ? Rt : 5'd0;
        end
    end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_r;

    // One pulse per unknown encoding, taken only when it would otherwise have entered EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= id_valid && !flush && !stall_id && !legal_s;
        end
    end

    assign illegal_instr = illegal_r;
`endif

    assign ex_valid = exValid_r;
    assign ex_ctrl  = exCtrl_r;
    assign ex_rt    = exRt_r;

    md_sequencer #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .issue   (issue_s),
        .op      (mdOp_s),
        .md_start(md_start),
        .md_op   (md_op),
        .md_busy (md_busy),
        .md_done (md_done)
    );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit with hand-computed control bundles.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic        flush;
    logic        stall_id;
    logic        ex_valid;
    logic [23:0] ex_ctrl;
    logic [4:0]  ex_rt;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_busy;
    logic        md_done;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .Opcode(Opcode), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_rt(ex_rt), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .md_done(md_done)
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    // Bundle order: rsvd, RegWrite, MemRead, MemWrite, MemtoReg, WriteDst, ALUSrc1, ALUSrc2,
    // ExtOp, LuOp, ALUOp, Jump, Branch, BranchOp, HiLoWr, HiLoRd.
    function automatic logic [23:0] mk(input logic rw, input logic mr, input logic mw,
                                       input logic [1:0] m2r, input logic [1:0] wd,
                                       input logic s1, input logic s2, input logic ext, input logic lu,
                                       input logic [3:0] alu, input logic j, input logic br,
                                       input logic [2:0] bop, input logic hw, input logic [1:0] hr);
        return {1'b0, rw, mr, mw, m2r, wd, s1, s2, ext, lu, alu, j, br, bop, hw, hr};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic fl);
        id_valid = v;
        Opcode   = op;
        Funct    = fn;
        Rs       = rs;
        Rt       = rt;
        flush    = fl;
    endtask

    task automatic dec_case(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic [23:0] exp);
        drive(1'b1, op, fn, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq({tag, "_ctrl"}, ex_ctrl, exp);
        check_eq({tag, "_valid"}, ex_valid, 1);
        @(posedge clk); #1;
    endtask

    // Samples from the first busy cycle until md_busy falls, bounded so a stuck unit still ends.
    task automatic md_measure(output int busyN, output int startN, output int doneK, output int stallN);
        busyN = 0; startN = 0; doneK = 0; stallN = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (md_busy)  busyN++;
            if (md_start) startN++;
            if (md_done)  doneK = k;
            if (stall_id) stallN++;
            if (!md_busy) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bN, sN, dK, stN;
        reset = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("rst_ex_valid", ex_valid, 0);
        check_eq("rst_ex_ctrl", ex_ctrl, 0);
        check_eq("rst_ex_rt", ex_rt, 0);
        check_eq("rst_md", {md_start, md_op, md_busy, md_done}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // lw $8 then add $9,$8,$1: one stall, one bubble
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 1'b0);
        @(negedge clk);
        check_eq("lw_nostall", stall_id, 0);
        @(posedge clk); #1;
        drive(1'b1, 6'h00, 6'h20, 5'd8, 5'd1, 1'b0);
        @(negedge clk);
        check_eq("lu_stall", stall_id, 1);
        check_eq("lu_lw_ctrl", ex_ctrl, mk(1,1,0,2'b01,2'b00,0,1,1,0,4'b1000,0,0,3'b111,0,2'b00));
        check_eq("lu_ex_rt", ex_rt, 8);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("lu_stall_once", stall_id, 0);
        check_eq("lu_bubble", ex_valid, 0);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("add_valid", ex_valid, 1);
        check_eq("add_ctrl", ex_ctrl, mk(1,0,0,2'b00,2'b01,0,0,1,0,4'b0010,0,0,3'b111,0,2'b00));
        check_eq("add_fields", {ex_ctrl[22], ex_ctrl[17:16], ex_ctrl[11:8]}, 7'b1_01_0010);
        @(posedge clk); #1;

        // div then mflo: mflo held until the unit frees
        drive(1'b1, 6'h00, 6'h1a, 5'd2, 5'd3, 1'b0);
        @(negedge clk);
        check_eq("div_nostall", stall_id, 0);
        @(posedge clk); #1;
        check_eq("div_ctrl", ex_ctrl, mk(0,0,0,2'b00,2'b01,0,0,1,0,4'b0010,0,0,3'b111,0,2'b00));
        drive(1'b1, 6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
        md_measure(bN, sN, dK, stN);
        check_eq("div_busy_cycles", bN, 32);
        check_eq("div_start_pulses", sN, 1);
        check_eq("div_done_cycle", dK, 32);
        check_eq("mflo_stall_cycles", stN, 32);
        check_eq("div_md_op", md_op, 2'b10);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("mflo_valid", ex_valid, 1);
        check_eq("mflo_ctrl", ex_ctrl, mk(1,0,0,2'b00,2'b01,0,0,1,0,4'b0010,0,0,3'b111,0,2'b10));
        @(posedge clk); #1;

        // decode table
        dec_case("jal",   6'h03, 6'h00, mk(1,0,0,2'b10,2'b10,0,1,1,0,4'b1000,1,0,3'b111,0,2'b00));
        dec_case("jalr",  6'h00, 6'h09, mk(1,0,0,2'b10,2'b01,0,0,1,0,4'b0010,1,0,3'b111,0,2'b00));
        dec_case("andi",  6'h0c, 6'h00, mk(1,0,0,2'b00,2'b00,0,1,0,0,4'b0100,0,0,3'b111,0,2'b00));
        dec_case("beq",   6'h04, 6'h00, mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0001,0,1,3'b000,0,2'b00));
        dec_case("lui",   6'h0f, 6'h00, mk(1,0,0,2'b00,2'b00,0,1,1,1,4'b1000,0,0,3'b111,0,2'b00));
        dec_case("sll",   6'h00, 6'h00, mk(1,0,0,2'b00,2'b01,1,0,1,0,4'b0010,0,0,3'b111,0,2'b00));
        dec_case("bltz",  6'h01, 6'h00, mk(0,0,0,2'b00,2'b00,0,1,1,0,4'b1000,0,1,3'b100,0,2'b00));
        dec_case("sltiu", 6'h0b, 6'h00, mk(1,0,0,2'b00,2'b00,0,1,1,0,4'b1101,0,0,3'b111,0,2'b00));
        dec_case("mthi",  6'h00, 6'h11, mk(0,0,0,2'b00,2'b01,0,0,1,0,4'b0010,0,0,3'b111,1,2'b00));

        // mult, lw, then flush coinciding with a load-use
        drive(1'b1, 6'h00, 6'h18, 5'd4, 5'd5, 1'b0);
        @(negedge clk);
        check_eq("mult_nostall", stall_id, 0);
        @(posedge clk); #1;
        drive(1'b1, 6'h23, 6'h00, 5'd1, 5'd8, 1'b0);
        @(negedge clk);
        check_eq("mult_start", {md_start, md_busy, md_op}, 4'b1_1_00);
        @(posedge clk); #1;
        drive(1'b1, 6'h00, 6'h20, 5'd8, 5'd1, 1'b1);
        @(negedge clk);
        check_eq("flush_nostall", stall_id, 0);
        check_eq("flush_lw_in_ex", ex_valid, 1);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("flush_bubble", {ex_valid, ex_ctrl}, 0);
        check_eq("mult_c3", {md_busy, md_done}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mult_c4_done", {md_busy, md_done}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mult_c5_idle", {md_busy, md_done}, 2'b00);
        @(posedge clk); #1;

        // reset during cycle 10 of a div, then a fresh mult
        drive(1'b1, 6'h00, 6'h1a, 5'd2, 5'd3, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 6'h09, 6'h00, 5'd0, 5'd0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check_eq("div_c10_busy", {md_busy, ex_valid, md_op}, 4'b1_1_10);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_md", {md_start, md_op, md_busy, md_done}, 0);
        check_eq("rst_mid_ex", {ex_valid, ex_ctrl}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 6'h00, 6'h18, 5'd4, 5'd5, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        md_measure(bN, sN, dK, stN);
        check_eq("post_rst_mult_busy", bN, 4);
        check_eq("post_rst_mult_start", sN, 1);
        check_eq("post_rst_mult_done", dK, 4);
        @(posedge clk); #1;

        // unknown opcode 0x3f
        drive(1'b1, 6'h3f, 6'h00, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        check_eq("illegal_pulse", {illegal_instr, ex_valid}, 2'b10);
`else
        check_eq("unknown_nop_valid", ex_valid, 1);
        check_eq("unknown_nop_ctrl", ex_ctrl, 0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("idle_after_unknown", ex_valid, 0);
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        check_eq("illegal_one_cycle", illegal_instr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
